// File: rtl/conf_int_add_rr_sched.sv
// Round-robin scheduler sharing one external approximate adder among
// NUM_REQ requesters, with a per-requester approximation table.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   req_valid/ready per-requester handshake (ready one-hot or zero)
//   req_a, req_b    flattened operands, requester k at [k*OP +: OP]
//   cfg_we/id/apx   config table write port (apx saturates to DP width)
//   add_a/b/apx     registered drive into the shared adder
//   add_d           adder result (combinational from add_*)
//   rsp_valid/ready response handshake, rsp_id/rsp_d held until taken
//   ops_done        wrapping count of accepted responses
module conf_int_add_rr_sched #(
  parameter int OP_BITWIDTH        = 32,
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int NUM_REQ            = 4,
  parameter int ID_W               = 2,
  parameter int APX_W              = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*OP_BITWIDTH-1:0]    req_a,
  input  logic [NUM_REQ*OP_BITWIDTH-1:0]    req_b,
  input  logic                              cfg_we,
  input  logic [ID_W-1:0]                   cfg_id,
  input  logic [APX_W-1:0]                  cfg_apx,
  output logic [DATA_PATH_BITWIDTH-1:0]     add_a,
  output logic [DATA_PATH_BITWIDTH-1:0]     add_b,
  output logic [APX_W-1:0]                  add_apx,
  input  logic [DATA_PATH_BITWIDTH-1:0]     add_d,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [ID_W-1:0]                   rsp_id,
  output logic [DATA_PATH_BITWIDTH-1:0]     rsp_d,
  output logic [15:0]                       ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [APX_W-1:0] APX_SAT =
    APX_W'(DATA_PATH_BITWIDTH);
  localparam logic [ID_W-1:0] LAST_RST =
    ID_W'(NUM_REQ - 1);

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   id_r;
  logic [APX_W-1:0]  cfg_table [NUM_REQ];

  logic              grant_eligible;
  logic              grant_found;
  logic              grant;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   cand;
  int                base;
  logic [OP_BITWIDTH-1:0] sel_a;
  logic [OP_BITWIDTH-1:0] sel_b;
  logic [APX_W-1:0]  cfg_wdata;

  // A response slot frees up in the same cycle it is accepted, so a
  // new grant can overlap the accept and sustain one op per 2 cycles.
  assign grant_eligible = (state == IDLE) ||
                          ((state == RESP) && rsp_ready);

  // Rotating search starting just after the previous winner.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign grant = grant_eligible && grant_found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    base  = int'(grant_id) * OP_BITWIDTH;
    sel_a = req_a[base +: OP_BITWIDTH];
    sel_b = req_b[base +: OP_BITWIDTH];
  end

  // Approximating more LSBs than the datapath has is meaningless.
  assign cfg_wdata = (int'(cfg_apx) > DATA_PATH_BITWIDTH) ?
                     APX_SAT : cfg_apx;

  // The grant reads the pre-edge table value, so a write that
  // coincides with a grant to the same ID only affects later grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_REQ; k++) cfg_table[k] <= '0;
    end else if (cfg_we && (int'(cfg_id) < NUM_REQ)) begin
      cfg_table[cfg_id] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= LAST_RST;
      id_r       <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_apx    <= '0;
      rsp_d      <= '0;
      rsp_id     <= '0;
      ops_done   <= '0;
    end else begin
      if ((state == RESP) && rsp_ready)
        ops_done <= ops_done + 16'd1;

      // Operand registers only move on a grant, so the adder inputs
      // stay put through EXEC and hold their value otherwise.
      if (grant) begin
        add_a      <= DATA_PATH_BITWIDTH'($signed(sel_a));
        add_b      <= DATA_PATH_BITWIDTH'($signed(sel_b));
        add_apx    <= cfg_table[grant_id];
        id_r       <= grant_id;
        last_grant <= grant_id;
      end

      unique case (state)
        IDLE: begin
          if (grant) state <= EXEC;
        end
        EXEC: begin
          rsp_d  <= add_d;
          rsp_id <= id_r;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= grant ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_conf_int_add_rr_sched.sv
// Directed bench for conf_int_add_rr_sched: table-driven single ops
// plus hand-written round-robin, backpressure, config, reset sequences.
module tb_conf_int_add_rr_sched;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         cfg_we;
  logic [1:0]   cfg_id;
  logic [5:0]   cfg_apx;
  logic [31:0]  add_a;
  logic [31:0]  add_b;
  logic [5:0]   add_apx;
  logic [31:0]  add_d;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_d;
  logic [15:0]  ops_done;

  logic [3:0]   s_req_valid;
  logic [3:0]   s_req_ready;
  logic [63:0]  s_req_a;
  logic [63:0]  s_req_b;
  logic [31:0]  s_add_a;
  logic [31:0]  s_add_b;
  logic [5:0]   s_add_apx;
  logic [31:0]  s_add_d;
  logic         s_rsp_valid;
  logic         s_rsp_ready;
  logic [1:0]   s_rsp_id;
  logic [31:0]  s_rsp_d;
  logic [15:0]  s_ops_done;

  int checks;
  int failures;

  conf_int_add_rr_sched u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_apx(cfg_apx),
    .add_a(add_a), .add_b(add_b), .add_apx(add_apx),
    .add_d(add_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_d(rsp_d), .ops_done(ops_done)
  );

  conf_int_add_rr_sched #(.OP_BITWIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_a(s_req_a), .req_b(s_req_b),
    .cfg_we(1'b0), .cfg_id(2'd0), .cfg_apx(6'd0),
    .add_a(s_add_a), .add_b(s_add_b), .add_apx(s_add_apx),
    .add_d(s_add_d),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_id(s_rsp_id), .rsp_d(s_rsp_d), .ops_done(s_ops_done)
  );

  // Lower k bits approximated as OR, upper bits added exactly.
  function automatic logic [31:0] apx_add(
    input logic [31:0] a, input logic [31:0] b, input logic [5:0] k);
    logic [31:0] m;
    if (k >= 6'd32) return a | b;
    m = (32'h1 << k) - 32'h1;
    return ((a & ~m) + (b & ~m)) | ((a | b) & m);
  endfunction

  always_comb add_d   = apx_add(add_a, add_b, add_apx);
  always_comb s_add_d = apx_add(s_add_a, s_add_b, s_add_apx);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [63:0] exp,
                     input logic [63:0] act);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 4; k++) begin
      req_a[k*32 +: 32] = a;
      req_b[k*32 +: 32] = b;
    end
  endtask

  // One complete op from IDLE: grant, EXEC, RESP, accept.
  task automatic run_op(input string nm,
                        input logic [3:0] v,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] er, input logic [5:0] eapx,
                        input logic [31:0] ed, input logic [1:0] eid);
    req_valid = v;
    set_ops(a, b);
    #1;
    chk({nm, ".ready"}, 64'(er), 64'(req_ready));
    step();
    req_valid = '0;
    cfg_we    = 1'b0;
    chk({nm, ".add_a"}, 64'(a), 64'(add_a));
    chk({nm, ".apx"}, 64'(eapx), 64'(add_apx));
    chk({nm, ".exec_rv"}, 64'(0), 64'(rsp_valid));
    step();
    chk({nm, ".rv"}, 64'(1), 64'(rsp_valid));
    chk({nm, ".d"}, 64'(ed), 64'(rsp_d));
    chk({nm, ".id"}, 64'(eid), 64'(rsp_id));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({nm, ".rv_off"}, 64'(0), 64'(rsp_valid));
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ready;
    logic [31:0] d;
    logic [1:0]  id;
  } vec_t;

  vec_t vt [5];

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    cfg_we    = 1'b0;
    cfg_id    = '0;
    cfg_apx   = '0;
    rsp_ready = 1'b0;
    s_req_valid = '0;
    s_req_a     = '0;
    s_req_b     = '0;
    s_rsp_ready = 1'b0;

    vt[0] = '{4'b0001, 32'd5, 32'hFFFF_FFFD, 4'b0001, 32'd2, 2'd0};
    vt[1] = '{4'b1111, 32'd100, 32'd23, 4'b0010, 32'd123, 2'd1};
    vt[2] = '{4'b1001, 32'hFFFF_FFFF, 32'd1, 4'b1000, 32'd0, 2'd3};
    vt[3] = '{4'b0110, 32'h7FFF_FFFF, 32'd1, 4'b0010,
              32'h8000_0000, 2'd1};
    vt[4] = '{4'b0001, 32'd40, 32'd2, 4'b0001, 32'd42, 2'd0};

    step();
    step();
    chk("rst.rv", 64'(0), 64'(rsp_valid));
    chk("rst.add_a", 64'(0), 64'(add_a));
    chk("rst.ops", 64'(0), 64'(ops_done));
    rst = 1'b0;
    step();
    chk("idle.ready", 64'(0), 64'(req_ready));
    chk("idle.rsp_d", 64'(0), 64'(rsp_d));

    for (int i = 0; i < 5; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].valid, vt[i].a, vt[i].b,
             vt[i].ready, 6'd0, vt[i].d, vt[i].id);
    end
    chk("vec.ops", 64'(5), 64'(ops_done));

    // Round-robin with every requester asking and rsp_ready held.
    for (int k = 0; k < 4; k++) begin
      req_a[k*32 +: 32] = 32'(k * 10);
      req_b[k*32 +: 32] = 32'd1;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      int g;
      g = (1 + i) % 4;
      chk($sformatf("rr%0d.ready", i), 64'(1 << g), 64'(req_ready));
      step();
      chk($sformatf("rr%0d.exec_rdy", i), 64'(0), 64'(req_ready));
      chk($sformatf("rr%0d.add_a", i), 64'(g * 10), 64'(add_a));
      step();
      chk($sformatf("rr%0d.rv", i), 64'(1), 64'(rsp_valid));
      chk($sformatf("rr%0d.id", i), 64'(g), 64'(rsp_id));
      chk($sformatf("rr%0d.d", i), 64'(g * 10 + 1), 64'(rsp_d));
    end
    req_valid = '0;
    step();
    rsp_ready = 1'b0;
    chk("rr.idle_rv", 64'(0), 64'(rsp_valid));
    chk("rr.ops", 64'(13), 64'(ops_done));

    // Backpressure: a pending request for 1 waits behind a stalled rsp.
    req_valid = 4'b0001;
    set_ops(32'd9, 32'd1);
    #1;
    chk("bp.ready0", 64'(1), 64'(req_ready));
    step();
    req_valid = 4'b0010;
    set_ops(32'd40, 32'd2);
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d.rv", i), 64'(1), 64'(rsp_valid));
      chk($sformatf("bp%0d.d", i), 64'(10), 64'(rsp_d));
      chk($sformatf("bp%0d.id", i), 64'(0), 64'(rsp_id));
      chk($sformatf("bp%0d.ready", i), 64'(0), 64'(req_ready));
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.grant1", 64'(4'b0010), 64'(req_ready));
    step();
    rsp_ready = 1'b0;
    req_valid = '0;
    chk("bp.exec_rv", 64'(0), 64'(rsp_valid));
    chk("bp.add_a", 64'(40), 64'(add_a));
    step();
    chk("bp.id1", 64'(1), 64'(rsp_id));
    chk("bp.d1", 64'(42), 64'(rsp_d));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp.ops", 64'(15), 64'(ops_done));

    // Config table: apply, saturate, same-cycle write ordering.
    cfg_we = 1'b1; cfg_id = 2'd2; cfg_apx = 6'd8;
    step();
    cfg_we = 1'b0;
    run_op("cfg8", 4'b0100, 32'h1FF, 32'h101, 4'b0100, 6'd8,
           32'h2FF, 2'd2);
    cfg_we = 1'b1; cfg_id = 2'd3; cfg_apx = 6'd63;
    step();
    cfg_we = 1'b0;
    run_op("cfgsat", 4'b1000, 32'd3, 32'd3, 4'b1000, 6'd32,
           32'd3, 2'd3);
    cfg_we = 1'b1; cfg_id = 2'd1; cfg_apx = 6'd5;
    run_op("cfgold", 4'b0010, 32'h1F, 32'h1, 4'b0010, 6'd0,
           32'h20, 2'd1);
    run_op("cfgnew", 4'b0010, 32'h1F, 32'h1, 4'b0010, 6'd5,
           32'h1F, 2'd1);
    chk("cfg.ops", 64'(19), 64'(ops_done));

    // Sign extension on the 16-bit-operand instance.
    s_req_valid = 4'b0001;
    s_req_a[15:0] = 16'hFFFF;
    s_req_b[15:0] = 16'h0001;
    #1;
    chk("sx.ready", 64'(1), 64'(s_req_ready));
    step();
    s_req_valid = '0;
    chk("sx.add_a", 64'(32'hFFFF_FFFF), 64'(s_add_a));
    chk("sx.add_b", 64'(1), 64'(s_add_b));
    step();
    chk("sx.rv", 64'(1), 64'(s_rsp_valid));
    chk("sx.d", 64'(0), 64'(s_rsp_d));
    s_rsp_ready = 1'b1;
    step();
    s_rsp_ready = 1'b0;

    // Async reset while in EXEC.
    req_valid = 4'b0100;
    set_ops(32'd7, 32'd8);
    step();
    req_valid = '0;
    chk("rx.pre_apx", 64'(8), 64'(add_apx));
    #1 rst = 1'b1;
    #1;
    chk("rx.add_a", 64'(0), 64'(add_a));
    chk("rx.add_b", 64'(0), 64'(add_b));
    chk("rx.apx", 64'(0), 64'(add_apx));
    chk("rx.ops", 64'(0), 64'(ops_done));
    chk("rx.ready", 64'(0), 64'(req_ready));
    #1 rst = 1'b0;
    step();
    chk("rx.after_rv", 64'(0), 64'(rsp_valid));

    // Async reset while a response is pending.
    req_valid = 4'b1000;
    set_ops(32'd3, 32'd4);
    step();
    req_valid = '0;
    step();
    chk("rr_rst.pre_rv", 64'(1), 64'(rsp_valid));
    #1 rst = 1'b1;
    #1;
    chk("rr_rst.rv", 64'(0), 64'(rsp_valid));
    chk("rr_rst.d", 64'(0), 64'(rsp_d));
    chk("rr_rst.id", 64'(0), 64'(rsp_id));
    #1 rst = 1'b0;
    step();
    step();
    chk("rr_rst.no_rv", 64'(0), 64'(rsp_valid));

    run_op("post0", 4'b1111, 32'd1, 32'd2, 4'b0001, 6'd0,
           32'd3, 2'd0);
    run_op("post2", 4'b0100, 32'h1FF, 32'h101, 4'b0100, 6'd0,
           32'h300, 2'd2);
    chk("post.ops", 64'(2), 64'(ops_done));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
